// File: rtl/decoder_4x16.sv
// Enabled 4-to-16 one-hot decoder. It provides a combinational view (y_comb)
// and an optionally registered view (y) with a valid flag that tracks en.
module decoder_4x16 #(
  parameter int REG_OUT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  i,
  output logic [15:0] y,
  output logic [15:0] y_comb,
  output logic        valid
);

  logic [15:0] y_d;
  logic [15:0] y_q;
  logic        valid_d;
  logic        valid_q;

  // A full case keeps an X index from producing a stray strobe.
  function automatic logic [15:0] decode(input logic [3:0] idx);
    logic [15:0] r;
    case (idx)
      4'h0:    r = 16'h0001;
      4'h1:    r = 16'h0002;
      4'h2:    r = 16'h0004;
      4'h3:    r = 16'h0008;
      4'h4:    r = 16'h0010;
      4'h5:    r = 16'h0020;
      4'h6:    r = 16'h0040;
      4'h7:    r = 16'h0080;
      4'h8:    r = 16'h0100;
      4'h9:    r = 16'h0200;
      4'hA:    r = 16'h0400;
      4'hB:    r = 16'h0800;
      4'hC:    r = 16'h1000;
      4'hD:    r = 16'h2000;
      4'hE:    r = 16'h4000;
      4'hF:    r = 16'h8000;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  always_comb begin
    y_comb  = en ? decode(i) : 16'h0000;
    y_d     = y_comb;
    valid_d = en;
  end

  // Output register stage: reset overrides enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      assign y     = y_q;
      assign valid = valid_q;
    end else begin : g_direct
      assign y     = y_comb;
      assign valid = en;
    end
  endgenerate

endmodule

// File: tb/tb_decoder_4x16.sv
// Self-checking bench for decoder_4x16: registered and direct builds side by side.
module tb_decoder_4x16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  i;
  logic [15:0] y1, yc1, y0, yc0;
  logic        v1, v0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  decoder_4x16 #(.REG_OUT(1)) dut_reg (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i),
    .y(y1), .y_comb(yc1), .valid(v1)
  );

  decoder_4x16 #(.REG_OUT(0)) dut_dir (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i),
    .y(y0), .y_comb(yc0), .valid(v0)
  );

  typedef struct {
    logic        en;
    logic [3:0]  idx;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[18];

  // Reference: the enabled line number is the index value, as a power of two.
  function automatic logic [15:0] ref_dec(input logic e, input logic [3:0] idx);
    int p;
    p = 1;
    for (int k = 0; k < int'(idx); k++) p = p * 2;
    return e ? p[15:0] : 16'h0000;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_y;
    logic        exp_v;
    logic [15:0] cur;

    vecs = '{
      '{1'b1, 4'h0, 16'h0001}, '{1'b1, 4'h1, 16'h0002},
      '{1'b1, 4'h2, 16'h0004}, '{1'b1, 4'h3, 16'h0008},
      '{1'b1, 4'h4, 16'h0010}, '{1'b1, 4'h5, 16'h0020},
      '{1'b1, 4'h6, 16'h0040}, '{1'b1, 4'h7, 16'h0080},
      '{1'b1, 4'h8, 16'h0100}, '{1'b1, 4'h9, 16'h0200},
      '{1'b1, 4'hA, 16'h0400}, '{1'b1, 4'hB, 16'h0800},
      '{1'b1, 4'hC, 16'h1000}, '{1'b1, 4'hD, 16'h2000},
      '{1'b1, 4'hE, 16'h4000}, '{1'b1, 4'hF, 16'h8000},
      '{1'b0, 4'hA, 16'h0000}, '{1'b1, 4'hA, 16'h0400}
    };

    // Reset held with enable high
    rst_n = 1'b0; en = 1'b1; i = 4'h5;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("reset_y", y1, 16'h0000);
      check("reset_valid", {15'b0, v1}, 16'h0000);
      check("reset_ycomb", yc1, 16'h0020);
    end

    // Table: sweep, disable, re-enable
    rst_n = 1'b1;
    for (int k = 0; k < 18; k++) begin
      en = vecs[k].en; i = vecs[k].idx;
      #1;
      check("tbl_ycomb", yc1, vecs[k].exp);
      check("tbl_direct_y", y0, vecs[k].exp);
      check("tbl_direct_valid", {15'b0, v0}, {15'b0, vecs[k].en});
      tick();
      check("tbl_reg_y", y1, vecs[k].exp);
      check("tbl_reg_valid", {15'b0, v1}, {15'b0, vecs[k].en});
    end

    // Mid-run reset while streaming index 15
    en = 1'b1; i = 4'hF;
    tick();
    check("stream_y", y1, 16'h8000);
    rst_n = 1'b0;
    #2;
    check("pre_edge_y", y1, 16'h8000);
    tick();
    check("midrst_y", y1, 16'h0000);
    check("midrst_valid", {15'b0, v1}, 16'h0000);
    check("midrst_direct_y", y0, 16'h8000);
    check("midrst_direct_valid", {15'b0, v0}, 16'h0001);
    rst_n = 1'b1;
    tick();
    check("recover_y", y1, 16'h8000);
    check("recover_valid", {15'b0, v1}, 16'h0001);

    // Reset pulse entirely between edges
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    check("glitch_y", y1, 16'h8000);
    check("glitch_valid", {15'b0, v1}, 16'h0001);
    tick();
    check("glitch_after_y", y1, 16'h8000);

    // Randomized traffic against the reference
    for (int n = 0; n < 300; n++) begin
      rst_n = ($urandom_range(0, 9) != 0);
      en    = ($urandom_range(0, 3) != 0);
      i     = 4'($urandom_range(0, 15));
      cur   = ref_dec(en, i);
      exp_y = rst_n ? cur : 16'h0000;
      exp_v = rst_n & en;
      #1;
      check("rnd_ycomb", yc1, cur);
      check("rnd_direct_y", y0, cur);
      check("rnd_direct_valid", {15'b0, v0}, {15'b0, en});
      tick();
      check("rnd_reg_y", y1, exp_y);
      check("rnd_reg_valid", {15'b0, v1}, {15'b0, exp_v});
      checks++;
      if (!$onehot0(y1) || (!v1 && y1 != 16'h0000)) begin
        errors++;
        $display("FAIL rnd_invariant: got y=%h valid=%b required onehot0 and y=0 when invalid", y1, v1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_4x16.md
Name: decoder_4x16

Overview:
- Enabled 4-to-16 one-hot decoder with a registered output stage.
- Converts a 4-bit binary index into a 16-bit one-hot word. When disabled, every output line is low.
- Used as a select/strobe generator: register-file write enables, chip selects, demux control.
- Provides a combinational one-hot view and a registered view, plus a registered valid flag.

Parameters:
- REG_OUT, 1, 1 = y is registered (1-cycle latency); 0 = y is driven directly from the combinational decode.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active low; sampled on the clk rising edge.
- en  input  1  decoder enable, active high.
- i  input  4  binary select index, 0..15.
- y  output  16  one-hot decoded output; bit n high when the decoded index is n and enable was high.
- y_comb  output  16  combinational decode of the current en/i, no latency.
- valid  output  1  registered copy of en, aligned with registered y.

Behaviour:
- Combinational decode:
  - y_comb = (16'h0001 << i) when en = 1.
  - y_comb = 16'h0000 when en = 0.
  - Exactly one bit of y_comb is high when en = 1; none when en = 0.
- Bit mapping: i = 0 -> bit 0, i = 15 -> bit 15 (MSB). Examples: i = 4'b1010 -> 16'h0400; i = 4'b1111 -> 16'h8000.
- Registered path (REG_OUT = 1):
  - Rising edge with rst_n = 0: y <= 16'h0000, valid <= 0, regardless of en and i.
  - Rising edge with rst_n = 1: y <= y_comb, valid <= en.
  - Latency is exactly one cycle: y reflects the en/i sampled at the previous rising edge.
- Direct path (REG_OUT = 0):
  - y = y_comb, valid = en, both combinational.
  - rst_n has no effect on y or valid in this configuration.
- Reset:
  - Synchronous only; asserting rst_n between edges does not change the outputs until the next rising edge.
  - y_comb ignores reset.
  - A reset asserted mid-operation clears y and valid on the next edge, even if en = 1 on that edge.
- Reset and enable together: reset wins. rst_n = 0 with en = 1 still yields y = 0 and valid = 0 after the edge.
- X/undriven i: no defined requirement, but no latch may be inferred. The decode is a full case; the default branch drives 16'h0000.
- Invariant: y is either all zeros or exactly one-hot ($onehot0(y) holds every cycle). valid = 0 implies y = 0.
- Changes on i while en = 0 never produce a nonzero output.

Test Plan:
- Reset: hold rst_n = 0 for 2 edges with en = 1, i = 4'h5 -> y = 16'h0000, valid = 0. y_comb = 16'h0020 throughout.
- Full sweep: rst_n = 1, en = 1, i = 0..15, one value per cycle -> y_comb = 1 << i immediately. y = 1 << i one cycle later (i = 0 -> 16'h0001 … i = 15 -> 16'h8000), valid = 1.
- Disable: en = 0, i = 4'b1010 -> y_comb = 16'h0000 at once, y = 16'h0000 and valid = 0 after one edge. Then en = 1 -> y = 16'h0400 one cycle later.
- Mid-run reset: en = 1, i = 4'hF streaming; pull rst_n low for one cycle -> y = 16'h0000 for that cycle. y returns to 16'h8000 on the first edge after rst_n = 1.
- Async check: toggle rst_n low and high between clock edges -> y and valid unchanged.
- REG_OUT = 0 build: repeat the sweep -> y equals y_comb with zero latency. rst_n low has no effect on y.
